// File: rtl/alu_selftest_driver_if.sv
// Operand/control and result/flag bundle between the self-test driver and the ALU.
interface alu_selftest_driver_if;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;

    modport master (
        output alu_a,
        output alu_b,
        output alu_ctrl,
        input  alu_result,
        input  alu_zero
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_ctrl,
        output alu_result,
        output alu_zero
    );
endinterface

// File: rtl/alu_selftest_driver.sv
// ALU self-test engine: directed prologue then LFSR vectors, checked against a golden model.
module alu_selftest_driver #(
    parameter int unsigned NUM_VECTORS = 32,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    alu_selftest_driver_if.master alu_if,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [15:0]           fail_count_o,
    output logic [15:0]           first_fail_idx_o,
    output logic [3:0]            first_fail_op_o
);

    localparam logic [31:0] Seed    = (LFSR_SEED == 32'd0) ? 32'h0000_0001 : LFSR_SEED;
    localparam logic [31:0] TapMask = 32'h8020_0003;
    localparam logic [15:0] NumVec  = 16'(NUM_VECTORS);
    localparam logic [15:0] NoFail  = 16'hFFFF;

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0001;
    localparam logic [3:0] OpAnd = 4'b0010;
    localparam logic [3:0] OpOr  = 4'b0011;
    localparam logic [3:0] OpSlt = 4'b1000;

    typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [15:0] idx_q, idx_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [31:0] exp_res_q, exp_res_d;
    logic        exp_zero_q, exp_zero_d;
    logic [15:0] fail_count_q, fail_count_d;
    logic [15:0] first_fail_idx_q, first_fail_idx_d;
    logic [3:0]  first_fail_op_q, first_fail_op_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    logic [31:0] vec_a, vec_b, vec_res, lfsr_next;
    logic [3:0]  vec_op, rand_op;
    logic        mismatch, accept;

    function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            OpAdd:   r = a + b;
            OpSub:   r = a - b;
            OpAnd:   r = a & b;
            OpOr:    r = a | b;
            OpSlt:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? TapMask : 32'd0);

    always_comb begin
        rand_op = OpSlt;
        case (op_q)
            3'd0:    rand_op = OpAdd;
            3'd1:    rand_op = OpSub;
            3'd2:    rand_op = OpAnd;
            3'd3:    rand_op = OpOr;
            default: rand_op = OpSlt;
        endcase
    end

    // Vector for the current index: directed prologue, then LFSR-derived operands.
    always_comb begin
        vec_a  = lfsr_q;
        vec_b  = {lfsr_q[15:0], lfsr_q[31:16]} ^ 32'h5A5A_5A5A;
        vec_op = rand_op;
        case (idx_q)
            16'd0:   begin vec_a = 32'd10; vec_b = 32'd5;  vec_op = OpAdd; end
            16'd1:   begin vec_a = 32'd10; vec_b = 32'd10; vec_op = OpSub; end
            16'd2:   begin vec_a = 32'd10; vec_b = 32'd5;  vec_op = OpAnd; end
            16'd3:   begin vec_a = 32'd10; vec_b = 32'd5;  vec_op = OpOr;  end
            16'd4:   begin vec_a = 32'd5;  vec_b = 32'd10; vec_op = OpSlt; end
            default: ;
        endcase
    end

    assign vec_res  = golden(vec_a, vec_b, vec_op);
    assign mismatch = (alu_if.alu_result != exp_res_q) || (alu_if.alu_zero != exp_zero_q);
    assign accept   = start_i && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        state_d          = state_q;
        lfsr_d           = lfsr_q;
        idx_d            = idx_q;
        op_d             = op_q;
        alu_a_d          = alu_a_q;
        alu_b_d          = alu_b_q;
        alu_ctrl_d       = alu_ctrl_q;
        exp_res_d        = exp_res_q;
        exp_zero_d       = exp_zero_q;
        fail_count_d     = fail_count_q;
        first_fail_idx_d = first_fail_idx_q;
        first_fail_op_d  = first_fail_op_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;

        unique case (state_q)
            StIdle: ;
            StDrive: begin
                alu_a_d    = vec_a;
                alu_b_d    = vec_b;
                alu_ctrl_d = vec_op;
                exp_res_d  = vec_res;
                exp_zero_d = (vec_res == 32'd0);
                state_d    = StCheck;
            end
            StCheck: begin
                if (mismatch) begin
                    if (fail_count_q != 16'hFFFF) begin
                        fail_count_d = fail_count_q + 16'd1;
                    end
                    // fail_count never wraps back to zero, so zero marks "no failure yet".
                    if (fail_count_q == 16'd0) begin
                        first_fail_idx_d = idx_q;
                        first_fail_op_d  = alu_ctrl_q;
                    end
                end
                if (idx_q >= 16'd5) begin
                    lfsr_d = lfsr_next;
                end
                op_d    = (op_q == 3'd4) ? 3'd0 : op_q + 3'd1;
                idx_d   = idx_q + 16'd1;
                state_d = (idx_d == NumVec) ? StDone : StDrive;
            end
            StDone: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = (fail_count_q == 16'd0);
            end
        endcase

        if (accept) begin
            state_d          = StDrive;
            lfsr_d           = Seed;
            idx_d            = 16'd0;
            op_d             = 3'd0;
            fail_count_d     = 16'd0;
            first_fail_idx_d = NoFail;
            first_fail_op_d  = 4'd0;
            busy_d           = 1'b1;
            done_d           = 1'b0;
            pass_d           = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            lfsr_q           <= Seed;
            idx_q            <= 16'd0;
            op_q             <= 3'd0;
            alu_a_q          <= 32'd0;
            alu_b_q          <= 32'd0;
            alu_ctrl_q       <= 4'd0;
            exp_res_q        <= 32'd0;
            exp_zero_q       <= 1'b0;
            fail_count_q     <= 16'd0;
            first_fail_idx_q <= NoFail;
            first_fail_op_q  <= 4'd0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            lfsr_q           <= lfsr_d;
            idx_q            <= idx_d;
            op_q             <= op_d;
            alu_a_q          <= alu_a_d;
            alu_b_q          <= alu_b_d;
            alu_ctrl_q       <= alu_ctrl_d;
            exp_res_q        <= exp_res_d;
            exp_zero_q       <= exp_zero_d;
            fail_count_q     <= fail_count_d;
            first_fail_idx_q <= first_fail_idx_d;
            first_fail_op_q  <= first_fail_op_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
        end
    end

    assign alu_if.alu_a     = alu_a_q;
    assign alu_if.alu_b     = alu_b_q;
    assign alu_if.alu_ctrl  = alu_ctrl_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign fail_count_o     = fail_count_q;
    assign first_fail_idx_o = first_fail_idx_q;
    assign first_fail_op_o  = first_fail_op_q;

endmodule

// File: tb/tb_alu_selftest_driver.sv
// Bench for alu_selftest_driver: fault-injectable ALU, vector-list reference model, per-cycle compare.
module tb_alu_selftest_driver;

    localparam int          NV   = 32;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] fail_count, ffi;
    logic [3:0]  ffo;

    alu_selftest_driver_if alu_if ();

    alu_selftest_driver #(
        .NUM_VECTORS(NV),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start),
        .alu_if          (alu_if),
        .busy_o          (busy),
        .done_o          (done),
        .pass_o          (pass),
        .fail_count_o    (fail_count),
        .first_fail_idx_o(ffi),
        .first_fail_op_o (ffo)
    );

    always #5 clk = ~clk;

    // 0: correct, 1: SUB computes ADD, 2: SLT unsigned, 3: bit flip on one opcode
    int         fault_mode = 0;
    int         fbit = 0;
    logic [3:0] fop = 4'd0;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op, input int mode,
                                           input int bitn, input logic [3:0] bop);
        logic [31:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = (mode == 1) ? a + b : a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd8:    r = (mode == 2) ? ((a < b) ? 32'd1 : 32'd0)
                                     : (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            default: r = 32'd0;
        endcase
        if (mode == 3 && op == bop) r = r ^ (32'd1 << bitn);
        return r;
    endfunction

    logic [31:0] tb_res;
    assign tb_res            = alu_fn(alu_if.alu_a, alu_if.alu_b, alu_if.alu_ctrl,
                                      fault_mode, fbit, fop);
    assign alu_if.alu_result = tb_res;
    assign alu_if.alu_zero   = (tb_res == 32'd0);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Reference: the full vector list of a run and which vectors the attached ALU gets wrong.
    logic [31:0] ma[NV];
    logic [31:0] mb[NV];
    logic [3:0]  mop[NV];
    bit          mfail[NV];
    logic [3:0]  opt[5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8};

    task automatic build_model();
        logic [31:0] l;
        logic [31:0] da[5] = '{32'd10, 32'd10, 32'd10, 32'd10, 32'd5};
        logic [31:0] db[5] = '{32'd5, 32'd10, 32'd5, 32'd5, 32'd10};
        l = SEED;
        for (int k = 0; k < NV; k++) begin
            if (k < 5) begin
                ma[k] = da[k]; mb[k] = db[k]; mop[k] = opt[k];
            end else begin
                ma[k]  = l;
                mb[k]  = {l[15:0], l[31:16]} ^ 32'h5A5A_5A5A;
                mop[k] = opt[k % 5];
                l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'd0);
            end
            mfail[k] = alu_fn(ma[k], mb[k], mop[k], fault_mode, fbit, fop)
                       != alu_fn(ma[k], mb[k], mop[k], 0, 0, 4'd0);
        end
    endtask

    // t = number of rising edges since the edge that accepted start.
    int t = 0;
    bit run_active = 1'b0;

    always @(negedge clk) begin
        int nchk, v, fc, fi;
        logic [3:0] fo;
        if (run_active) begin
            nchk = (t / 2 > NV) ? NV : t / 2;
            fc = 0; fi = 16'hFFFF; fo = 4'd0;
            for (int k = 0; k < nchk; k++) begin
                if (mfail[k]) begin
                    if (fc == 0) begin fi = k; fo = mop[k]; end
                    fc++;
                end
            end
            chk("busy", busy, (t <= 2 * NV) ? 1 : 0);
            chk("done", done, (t >= 2 * NV + 1) ? 1 : 0);
            chk("pass", pass, (t >= 2 * NV + 1 && fc == 0) ? 1 : 0);
            chk("fail_count", fail_count, fc);
            chk("first_fail_idx", ffi, fi);
            chk("first_fail_op", ffo, fo);
            if (t >= 1) begin
                v = ((t - 1) / 2 > NV - 1) ? NV - 1 : (t - 1) / 2;
                chk("alu_a", alu_if.alu_a, ma[v]);
                chk("alu_b", alu_if.alu_b, mb[v]);
                chk("alu_ctrl", alu_if.alu_ctrl, mop[v]);
            end
            t++;
        end
    end

    task automatic check_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail_count", fail_count, 0);
        chk("rst_first_fail_idx", ffi, 32'h0000_FFFF);
        chk("rst_first_fail_op", ffo, 0);
        chk("rst_alu_a", alu_if.alu_a, 0);
        chk("rst_alu_b", alu_if.alu_b, 0);
        chk("rst_alu_ctrl", alu_if.alu_ctrl, 0);
    endtask

    task automatic run_start();
        build_model();
        repeat ($urandom_range(0, 4)) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t = 0;
        run_active = 1'b1;
    endtask

    task automatic run_once(input bit pulse_mid);
        int e;
        run_start();
        e = 0;
        while (!done && e < 300) begin
            @(posedge clk);
            #1;
            e++;
            start = (pulse_mid && e == 7) ? 1'b1 : 1'b0;
            if (pulse_mid && e == 11) begin
                chk("vec5_alu_a", alu_if.alu_a, 32'hACE1_2468);
                chk("vec5_alu_b", alu_if.alu_b, 32'h7E32_F6BB);
                chk("vec5_alu_ctrl", alu_if.alu_ctrl, 4'b0000);
            end
        end
        start = 1'b0;
        chk("done_cycle", e, 2 * NV + 1);
        repeat (3) @(negedge clk);
        #1;
        run_active = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        fault_mode = 0;
        run_once(1'b1);
        chk("good_pass", pass, 1);
        chk("good_fail_count", fail_count, 0);
        chk("good_ffi", ffi, 32'h0000_FFFF);
        run_once(1'b0);

        fault_mode = 1;
        run_once(1'b0);
        chk("subadd_ffi", ffi, 1);
        chk("subadd_ffo", ffo, 4'b0001);
        chk("subadd_pass", pass, 0);

        fault_mode = 2;
        run_once(1'b0);
        chk("sltu_ffi", ffi, 9);
        chk("sltu_ffo", ffo, 4'b1000);

        for (int i = 0; i < 3; i++) begin
            fault_mode = 3;
            fbit = $urandom_range(0, 31);
            fop  = opt[$urandom_range(0, 4)];
            run_once(1'b0);
        end

        // Reset in the middle of a failing run.
        fault_mode = 1;
        run_start();
        repeat (21) @(posedge clk);
        #2;
        run_active = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        fault_mode = 0;
        run_once(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_selftest_driver.md
Name: alu_selftest_driver

Overview:
- Sequential stimulus/check engine that drives the ALU's operand/control interface and checks the ALU's result and zero flag against an internal golden model.
- Used for power-on/BIST of the single-cycle core's ALU and as a synthesizable bench driver.
- Runs a fixed directed prologue, then LFSR-generated vectors cycling through ADD, SUB, AND, OR, SLT.
- Reports pass/fail, error count and first failing vector.

Parameters:
- NUM_VECTORS, 32, total vectors per run including the 5 directed ones; legal range 5..65535.
- LFSR_SEED, 32'hACE1_2468, initial LFSR state; a value of 0 is replaced by 32'h0000_0001.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a run when in IDLE or DONE.
- alu_a  output  32  operand A to ALU.
- alu_b  output  32  operand B to ALU.
- alu_ctrl  output  4  ALU control: ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 1000.
- alu_result  input  32  ALU result (combinational from alu_a/alu_b/alu_ctrl).
- alu_zero  input  1  ALU zero flag.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  high in DONE; stays high until the next start or reset.
- pass  output  1  valid when done=1; 1 iff fail_count==0.
- fail_count  output  16  number of mismatching vectors in the current or last run; saturates at 16'hFFFF.
- first_fail_idx  output  16  index of the first failing vector; 16'hFFFF if none.
- first_fail_op  output  4  alu_ctrl of the first failing vector; 4'h0 if none.

Behaviour:
- Reset (async, rst_n=0):
  - State to IDLE.
  - alu_a, alu_b, alu_ctrl = 0.
  - busy = done = pass = 0; fail_count = 0.
  - first_fail_idx = 16'hFFFF; first_fail_op = 0.
  - LFSR loads the seed; vector index and op counter = 0.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE/DONE with start=1:
  - Clear done, pass, fail_count and first_fail_* (idx=16'hFFFF).
  - Reload the LFSR with the seed; index = 0; op counter = 0; go to DRIVE.
- start while in DRIVE or CHECK is ignored.
- DRIVE (1 cycle):
  - Register alu_a, alu_b and alu_ctrl for the current index.
  - Register the expected result and expected zero from the same values.
  - Go to CHECK.
- CHECK (1 cycle):
  - Mismatch if alu_result != expected result or alu_zero != expected zero.
  - On mismatch, fail_count increments (saturating). If this is the first failure, capture index into first_fail_idx and alu_ctrl into first_fail_op.
  - Advance the LFSR if index>=5; advance the op counter modulo 5; index++.
  - If the new index == NUM_VECTORS, go to DONE; otherwise go to DRIVE.
- DONE: busy=0, done=1, pass=(fail_count==0). Operand outputs hold their last values.
- Timing: 2 cycles per vector. With start sampled at edge 0, done rises at edge 2*NUM_VECTORS+1.
- Directed vectors, index 0..4:
  - 0: (10, 5, ADD) -> 15, zero 0
  - 1: (10, 10, SUB) -> 0, zero 1
  - 2: (10, 5, AND) -> 0, zero 1
  - 3: (10, 5, OR) -> 15, zero 0
  - 4: (5, 10, SLT) -> 1, zero 0
- Random vectors, index >= 5:
  - A = LFSR state.
  - B = {lfsr[15:0], lfsr[31:16]} ^ 32'h5A5A_5A5A.
  - op = ADD, SUB, AND, OR, SLT selected by the op counter; index 5 uses ADD.
- LFSR: 32-bit Galois, taps mask 32'h8020_0003. Shift right; if the shifted-out LSB is 1, XOR the mask. Advances once per random vector in CHECK.
- Golden model:
  - ADD/SUB: modulo 2^32, carry/borrow discarded.
  - AND/OR: bitwise.
  - SLT: signed two's-complement compare, result 32'd1 or 32'd0.
  - Undefined ctrl never generated.
  - Expected zero = (expected result == 0).
- Reset mid-run aborts immediately to the reset state; no partial status is retained.

Test Plan:
- Correct ALU model attached, NUM_VECTORS=32, pulse start -> done rises exactly 65 cycles after start; pass=1, fail_count=0, first_fail_idx=16'hFFFF.
- Faulty ALU (SUB implemented as ADD), NUM_VECTORS=5 -> fail_count=1, first_fail_idx=1, first_fail_op=4'b0001, pass=0.
- Faulty ALU (SLT unsigned), NUM_VECTORS=5 with vector 4 passing -> check that the index-5+ random run (NUM_VECTORS=40) reports a nonzero fail_count and an SLT-only first_fail_op=4'b1000.
- Default seed, probe at index 5 DRIVE -> alu_a=32'hACE1_2468, alu_ctrl=0000, alu_b=32'h2468_ACE1^32'h5A5A_5A5A.
- Pulse start again during busy at cycle 7 -> run unaffected, same completion cycle; start after done clears fail_count/first_fail_* and the run repeats identically.
- Assert rst_n=0 mid-CHECK -> all outputs at reset values asynchronously; a new start after release runs from index 0.
